// File: rtl/fft_pkg.sv
// Shared types for the radix-2 DIF front end: complex sample payload and pair-buffer state.
package fft_pkg;

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] i;
  } complex_fp_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_e;

endpackage

// File: rtl/pair_buf_ram.sv
// Half-frame sample store: one synchronous write port, one combinational read port.
module pair_buf_ram
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  complex_fp_t       wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output complex_fp_t       rd_data_o
);

  complex_fp_t mem_q [DEPTH];

  // Contents are deliberately left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fft_pair_buffer.sv
// Pairs x[k] with x[k+HALF_N] for the DIF butterfly; buffers the first half-frame.
// Optional frame resync on in_sof when FFT_PAIR_SOF_CHECK_EN is defined.
module fft_pair_buffer
  import fft_pkg::*;
#(
  parameter int unsigned HALF_N = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  complex_fp_t in_data,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output complex_fp_t out_a,
  output complex_fp_t out_b,
  output logic        out_last,
  output logic        sof_err
);

  localparam int unsigned AW       = $clog2(HALF_N);
  localparam logic [AW-1:0] IDX_LAST = AW'(HALF_N - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  complex_fp_t   out_a_q, out_a_d;
  complex_fp_t   out_b_q, out_b_d;
  logic          out_last_q, out_last_d;
  logic          sof_err_q, sof_err_d;

  logic          accept_c;
  logic          resync_c;
  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  complex_fp_t   rd_data_c;

  // FILL never back-pressures; the pending pair is already registered.
  assign in_ready = (state_q == FILL) || !out_valid_q || out_ready;
  assign accept_c = in_valid && in_ready;

`ifdef FFT_PAIR_SOF_CHECK_EN
  assign resync_c = in_sof && ((state_q != FILL) || (idx_q != '0));
`else
  logic unused_sof;
  assign unused_sof = in_sof;
  assign resync_c   = 1'b0;
`endif

  pair_buf_ram #(
    .DEPTH (HALF_N),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_addr_c),
    .wr_data_i (in_data),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data_c)
  );

  // Next-state: FSM, index counter, output register, RAM write strobe.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_last_d  = out_last_q;
    sof_err_d   = 1'b0;
    wr_en_c     = 1'b0;
    wr_addr_c   = idx_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept_c) begin
      if (resync_c) begin
        wr_en_c   = 1'b1;
        wr_addr_c = '0;
        idx_d     = AW'(1);
        state_d   = FILL;
        sof_err_d = 1'b1;
      end else if (state_q == FILL) begin
        wr_en_c = 1'b1;
        idx_d   = idx_q + AW'(1);
        if (idx_q == IDX_LAST) begin
          state_d = PAIR;
        end
      end else begin
        out_a_d     = rd_data_c;
        out_b_d     = in_data;
        out_last_d  = (idx_q == IDX_LAST);
        out_valid_d = 1'b1;
        idx_d       = idx_q + AW'(1);
        if (idx_q == IDX_LAST) begin
          state_d = FILL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_last_q  <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_last_q  <= out_last_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_last  = out_last_q;
  assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_fft_pair_buffer.sv
// Self-checking bench for fft_pair_buffer (HALF_N = 4) against a frame-level pairing model.
// Honours FFT_PAIR_SOF_CHECK_EN in the model the same way the design does.
module tb_fft_pair_buffer;
  import fft_pkg::*;

  localparam int H = 4;

  typedef struct {
    complex_fp_t a;
    complex_fp_t b;
    logic        last;
  } pair_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  complex_fp_t in_data;
  logic        in_sof;
  logic        out_valid;
  logic        out_ready;
  complex_fp_t out_a;
  complex_fp_t out_b;
  logic        out_last;
  logic        sof_err;

  fft_pair_buffer #(.HALF_N(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_last  (out_last),
    .sof_err   (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  pair_t       exp_q[$];
  complex_fp_t frame[2*H];
  int          n_pos;
  logic        exp_sof;
  int          ordy_mode;
  int          stall_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic complex_fp_t mk(input int r, input int i);
    complex_fp_t c;
    c.r = 16'(r);
    c.i = 16'(i);
    return c;
  endfunction

  // Frame model: sample n of a frame pairs with sample n-H once n >= H.
  task automatic model_accept(input complex_fp_t d, input logic resync);
    if (resync) begin
      n_pos   = 0;
      exp_sof = 1'b1;
    end
    frame[n_pos] = d;
    if (n_pos >= H) begin
      exp_q.push_back('{a: frame[n_pos-H], b: d, last: (n_pos == 2*H-1)});
    end
    n_pos = (n_pos + 1) % (2*H);
  endtask

  task automatic step(input logic v, input complex_fp_t d, input logic sof, output logic acc);
    logic ordy;
    logic exp_rdy;
    logic resync;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_a", out_a, exp_q[0].a);
      chk("out_b", out_b, exp_q[0].b);
      chk("out_last", 32'(out_last), 32'(exp_q[0].last));
    end
    chk("sof_err", 32'(sof_err), 32'(exp_sof));
    exp_sof = 1'b0;
    case (ordy_mode)
      1:       ordy = 1'($urandom % 2);
      2: begin
        ordy = 1'b1;
        if (exp_q.size() != 0 && stall_left > 0) begin
          ordy = 1'b0;
          stall_left--;
        end
      end
      default: ordy = 1'b1;
    endcase
    in_valid  = v;
    in_data   = d;
    in_sof    = sof;
    out_ready = ordy;
    #1;
    exp_rdy = (n_pos < H) || (exp_q.size() == 0) || ordy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (exp_q.size() != 0 && ordy) begin
      void'(exp_q.pop_front());
    end
    resync = 1'b0;
`ifdef FFT_PAIR_SOF_CHECK_EN
    resync = sof && (n_pos != 0);
`endif
    if (acc) model_accept(d, resync);
  endtask

  task automatic send(input complex_fp_t d, input logic sof);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      step(1'b1, d, sof, acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, acc);
  endtask

  task automatic drain();
    int save;
    int b;
    save      = ordy_mode;
    ordy_mode = 0;
    b         = 0;
    while (exp_q.size() != 0 && b < 20) begin
      idle(1);
      b++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    idle(1);
    ordy_mode = save;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sof_err", 32'(sof_err), 32'd0);
    @(negedge clk);
    chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    exp_q.delete();
    n_pos   = 0;
    exp_sof = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    n_pos      = 0;
    exp_sof    = 1'b0;
    ordy_mode  = 0;
    stall_left = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sof     = 1'b0;
    out_ready  = 1'b1;
    do_reset();

    // Single frame, full rate.
    for (int n = 0; n < 2*H; n++) send(mk(n, -n), 1'b0);
    drain();

    // Downstream stall of 3 cycles on the first pair.
    ordy_mode  = 2;
    stall_left = 3;
    for (int n = 0; n < 2*H; n++) send(mk(n, -n), 1'b0);
    drain();

    // Two frames back to back with random payloads.
    ordy_mode = 0;
    for (int n = 0; n < 4*H; n++) send(mk(int'($urandom), int'($urandom)), 1'b0);
    drain();

    // Reset mid-frame, then a fresh frame.
    for (int n = 0; n < 6; n++) send(mk(50 + n, 0), 1'b0);
    do_reset();
    for (int n = 0; n < 2*H; n++) send(mk(100 + n, -(100 + n)), 1'b0);
    drain();

    // Start-of-frame marker on the third sample.
    for (int n = 0; n < 2*H + 2; n++) send(mk(200 + n, n), (n == 0) || (n == 2));
    drain();
    do_reset();

    // Random gaps, random back-pressure, occasional stray in_sof.
    ordy_mode = 1;
    for (int n = 0; n < 8*H; n++) begin
      if ($urandom % 4 == 0) idle(1);
      send(mk(int'($urandom), int'($urandom)), 1'($urandom % 16 == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
